fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream consumer of sync_fifo: pops 8-bit bytes whenever the FIFO is non-empty
//  and serialises each one as an asynchronous UART frame on a single line.
//  Frame: start(0), data LSB first, optional parity, stop bit(s) at 1.
//  Drives the FIFO rd strobe directly.
//  sync_fifo read timing: dataout is valid on the clock edge after the edge that samples rd=1.
// PARAMETERS
//  DATA_W        8    data bits per frame; must equal the FIFO width
//  CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200); minimum 4
//  PARITY_EN     0    1 = insert parity bit after the data bits
//  PARITY_ODD    0    0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
//  STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//  clk         in   1       system clock, shared with sync_fifo
//  rst_n       in   1       asynchronous active-low reset
//  enable      in   1       1 = allowed to start new frames
//  fifo_empty  in   1       sync_fifo empty flag
//  fifo_rd     out  1       sync_fifo rd strobe, one-cycle pulse per byte
//  fifo_dout   in   DATA_W  sync_fifo dataout
//  tx          out  1       serial line, idle high
//  busy        out  1       1 from the fifo_rd pulse until the last stop bit ends
//  tx_done     out  1       one-cycle pulse on the last clk of the final stop bit
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - tx=1, fifo_rd=0, busy=0, tx_done=0, baud/bit counters=0, state=IDLE, shadow valid=0.
//   - Reset mid-frame forces tx high immediately; the byte in flight is discarded.
//  States:
//   - IDLE: enable & !fifo_empty -> fifo_rd=1 for 1 clk, go to FETCH.
//   - FETCH: 1 clk (FIFO read latency), go to LOAD.
//   - LOAD: capture fifo_dout into the shift register, go to START.
//   - START: tx=0 for CLKS_PER_BIT.
//   - DATA: DATA_W bits, each CLKS_PER_BIT, LSB first.
//   - PARITY: only when PARITY_EN=1. Value = ^data ^ PARITY_ODD.
//   - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT.
//  Baud counter:
//   - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, wraps to 0; resets on every state entry.
//   - Bit counter width $clog2(DATA_W+1).
//  Prefetch for back-to-back frames:
//   - On the first clk of STOP, if enable & !fifo_empty: pulse fifo_rd.
//   - Two clks later, capture fifo_dout into a shadow register and set shadow valid.
//   - At the end of STOP: shadow valid -> go to START directly (no idle gap) and load the shift register from the shadow; otherwise -> IDLE.
//  Handshake rules:
//   - fifo_rd is never asserted while fifo_empty=1, and never on two consecutive clks.
//   - At most one byte is outstanding (shift register + shadow <= 2 bytes).
//  enable:
//   - enable=0 mid-frame: the current frame completes; no new fetch starts while enable=0.
//   - A prefetch already issued still transmits.
//  Timing:
//   - tx is registered.
//   - Latency from the IDLE fifo_rd pulse to the tx falling edge: 3 clks.
// STRUCTURE
//  Shared package uart_pkg:
//   - state encoding localparams (IDLE, FETCH, LOAD, START, DATA, PARITY, STOP)
//   - parity mode constants
//   - default CLKS_PER_BIT
//  Sub-module uart_baud_tick:
//   - baud counter with clear input; outputs a one-clk tick on the last cycle of each bit
//  Top-level: FSM, shift register, shadow register, parity.
// TESTING  (50 MHz tb clock, CLKS_PER_BIT=4, real sync_fifo instance)
//  1. Hold rst_n=0 for 100 ns -> tx=1, fifo_rd=0, busy=0, tx_done=0 throughout.
//  2. Write 0xA5, PARITY_EN=0:
//     - exactly one fifo_rd pulse
//     - tx = 0,1,0,1,0,0,1,0,1,1, each 4 clks (40 clks total)
//     - tx_done pulses once on the final clk
//  3. Preload 0x00..0x03:
//     - 4 fifo_rd pulses, then empty
//     - frames start exactly 40 clks apart with no idle high between stop and next start
//  4. PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit = 1.
//     Same setup with PARITY_ODD=1 -> parity bit = 0. Frame is 44 clks.
//  5. Deassert rst_n during data bit 3 -> tx=1 in the same cycle.
//     After release, the next FIFO byte is sent cleanly; the interrupted byte is not resent.
//  6. enable=0 during DATA with the FIFO non-empty:
//     - current frame finishes
//     - no fifo_rd while enable=0
//     - fifo_rd is never high when fifo_empty=1 (assertion checked for the whole run)

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Holds the FSM state encoding, parity mode constants and default baud divisor.
`timescale 1ns/1ps
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } tx_state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Zero-extending narrower data into d leaves its parity unchanged.
  function automatic logic parity_bit(input logic [31:0] d, input bit odd);
    return (^d) ^ (odd == PAR_ODD);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side connection between sync_fifo and the UART transmitter.
`timescale 1ns/1ps
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  // fifo_rd is a one-clk pulse, only raised while fifo_empty=0 and never on two
  // consecutive clks; fifo_dout holds the popped byte from the edge after the edge
  // that samples fifo_rd=1.
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_dout;

  modport master (output fifo_rd, input fifo_empty, input fifo_dout);
  modport slave  (input fifo_rd, output fifo_empty, output fifo_dout);
endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and flags the last clk of every bit period.
`timescale 1ns/1ps
module fifo_uart_tx_baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a sync_fifo: fetches bytes, frames them and shifts them out
// on tx, prefetching the next byte during the stop bit so frames run back to back.
`timescale 1ns/1ps
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = PAR_EVEN,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done,
  output tx_state_e             state_dbg
);
  localparam int BIT_W = $clog2(DATA_W + 1);

  tx_state_e         state;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shadow_q;
  logic              shadow_vld;
  logic              par_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [1:0]        pf_pipe;
  logic              stop_first;
  logic              tick;
  logic              baud_clear;
  logic              line_val;

  assign state_dbg  = state;
  assign baud_clear = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_LOAD);

  fifo_uart_tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .tick (tick)
  );

  // Line level for the current state; tx is its registered copy, one clk behind.
  always_comb begin
    line_val = 1'b1;
    case (state)
      ST_START:  line_val = 1'b0;
      ST_DATA:   line_val = shift_q[0];
      ST_PARITY: line_val = par_q;
      default:   line_val = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      shift_q      <= '0;
      shadow_q     <= '0;
      shadow_vld   <= 1'b0;
      par_q        <= 1'b0;
      bit_cnt      <= '0;
      pf_pipe      <= '0;
      stop_first   <= 1'b0;
      fifo.fifo_rd <= 1'b0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      fifo.fifo_rd <= 1'b0;
      tx_done      <= 1'b0;
      stop_first   <= 1'b0;
      tx           <= line_val;
      busy         <= (state != ST_IDLE);
      pf_pipe      <= {pf_pipe[0], 1'b0};

      // Prefetched byte appears on fifo_dout two clks after its rd pulse.
      if (pf_pipe[1]) begin
        shadow_q   <= fifo.fifo_dout;
        shadow_vld <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (enable && !fifo.fifo_empty) begin
            fifo.fifo_rd <= 1'b1;
            busy         <= 1'b1;
            state        <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          shift_q <= fifo.fifo_dout;
          par_q   <= parity_bit(32'(fifo.fifo_dout), PARITY_ODD);
          bit_cnt <= '0;
          state   <= ST_START;
        end
        ST_START: if (tick) state <= ST_DATA;
        ST_DATA: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              if (PARITY_EN) begin
                state <= ST_PARITY;
              end else begin
                state      <= ST_STOP;
                stop_first <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state      <= ST_STOP;
            stop_first <= 1'b1;
          end
        end
        ST_STOP: begin
          if (stop_first && enable && !fifo.fifo_empty) begin
            fifo.fifo_rd <= 1'b1;
            pf_pipe[0]   <= 1'b1;
          end
          if (tick) begin
            if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
              tx_done <= 1'b1;
              bit_cnt <= '0;
              if (shadow_vld) begin
                shift_q    <= shadow_q;
                par_q      <= parity_bit(32'(shadow_q), PARITY_ODD);
                shadow_vld <= 1'b0;
                state      <= ST_START;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
